memory_reader: RTL

Read-side controller for the 4-entry × 8-bit byte memory that the store path writes on a button press. It issues single-cycle read requests to the memory's synchronous read port and registers the returned byte for display on the LEDs. A read is triggered either by a debounced read button at a switch-selected address or by an optional auto-scan that walks addresses 0→3 at a fixed rate. It sits beside the memory's write path in the board top level, driven from the board clock.

---
 rtl/memory_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/memory_reader.sv
// Read-side controller for the 4 x 8-bit byte memory: debounced button reads at a selected
// address, optional periodic auto-scan of all four addresses, result registered for display.
module memory_reader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_TICKS      = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       read_btn,
    input  logic       scan_en,
    input  logic [1:0] sel_addr,
    output logic       mem_rd,
    output logic [1:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic [7:0] data_out,
    output logic [1:0] addr_out,
    output logic       valid,
    output logic       busy
);

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ScanW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StCapture} state_e;

    state_e           state;
    logic             btn_meta;
    logic             btn_sync;
    logic             btn_deb;
    logic             btn_deb_prev;
    logic [DbW-1:0]   db_cnt;
    logic             btn_req;
    logic [ScanW-1:0] scan_timer;
    logic             scan_req;
    logic [1:0]       scan_ptr;
    logic [1:0]       rd_addr;
    logic             rd_scan;

    // Two-flop synchronizer followed by a stability counter on the synchronized level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta     <= 1'b0;
            btn_sync     <= 1'b0;
            btn_deb      <= 1'b0;
            btn_deb_prev <= 1'b0;
            db_cnt       <= '0;
        end else begin
            btn_meta     <= read_btn;
            btn_sync     <= btn_meta;
            btn_deb_prev <= btn_deb;
            if (btn_sync != btn_deb) begin
                if (db_cnt == DbLast) begin
                    btn_deb <= btn_sync;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign btn_req = btn_deb & ~btn_deb_prev;

    // The timer freezes while a read is in flight so scan reads stay SCAN_TICKS+2 apart.
    assign scan_req = scan_en && (state == StIdle) && (scan_timer == ScanLast);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_timer <= '0;
        end else if (!scan_en) begin
            scan_timer <= '0;
        end else if (state == StIdle) begin
            if (scan_timer == ScanLast) begin
                scan_timer <= '0;
            end else begin
                scan_timer <= scan_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            mem_rd   <= 1'b0;
            mem_addr <= 2'd0;
            data_out <= 8'd0;
            addr_out <= 2'd0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            rd_addr  <= 2'd0;
            rd_scan  <= 1'b0;
            scan_ptr <= 2'd0;
        end else begin
            case (state)
                StIdle: begin
                    // Button wins a tie with the scan timer; the scan request is simply lost.
                    if (btn_req) begin
                        rd_addr  <= sel_addr;
                        rd_scan  <= 1'b0;
                        mem_addr <= sel_addr;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StReq;
                    end else if (scan_req) begin
                        rd_addr  <= scan_ptr;
                        rd_scan  <= 1'b1;
                        mem_addr <= scan_ptr;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= StReq;
                    end
                end
                StReq: begin
                    mem_rd   <= 1'b0;
                    mem_addr <= 2'd0;
                    state    <= StCapture;
                end
                StCapture: begin
                    data_out <= mem_data;
                    addr_out <= rd_addr;
                    valid    <= 1'b1;
                    if (rd_scan) begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    mem_rd   <= 1'b0;
                    mem_addr <= 2'd0;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule
